// File: rtl/avalon_onchip_ram_pipe.sv
// avalon_onchip_ram_pipe: on-chip RAM behind an Avalon-MM pipelined slave, byte-enabled writes, read latency 1 or 2.
// Ports: clk/reset_n (async active-low), clken/reset_req stall inputs, chipselect/read/write/address/
// byteenable/writedata request side, readdata/readdatavalid response, waitrequest stall, init_done ready flag.
// Macro ONCHIP_RAM_SCRUB_EN: zero-fill the whole RAM after reset before accepting traffic.
module avalon_onchip_ram_pipe #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 11,
  parameter int DEPTH        = 2048,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "UNUSED"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  reset_req,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  init_done
);
  localparam int BE_W = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic stall, in_range, wr_acc, rd_acc, clr_we, mem_we;
  logic [ADDR_W-1:0] cnt_q, mem_addr;
  logic [BE_W-1:0] mem_be;
  logic [DATA_W-1:0] mem_wdata, rd_word, d1_q, d1_d, src_d, readdata_q, readdata_d;
  logic v1_q, v1_d, src_v, rdv_q, rdv_d;
  assign stall       = ~clken | reset_req | ~init_done;
  assign waitrequest = stall;
  assign in_range    = {1'b0, address} < (ADDR_W+1)'(DEPTH);
  assign wr_acc      = chipselect & write & ~stall;
  assign rd_acc      = chipselect & read & ~write & ~stall;
`ifdef ONCHIP_RAM_SCRUB_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = (state_q == CLEAR) & clken & ~reset_req;
    if (clr_we) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == ADDR_W'(DEPTH - 1)) ? READY : CLEAR;
    end
  end
  assign init_done = state_q == READY;
`else
  assign clr_we    = 1'b0;
  assign cnt_q     = '0;
  assign init_done = 1'b1;
`endif
  assign mem_we    = clr_we | (wr_acc & in_range);
  assign mem_addr  = clr_we ? cnt_q : address;
  assign mem_be    = clr_we ? '1 : byteenable;
  assign mem_wdata = clr_we ? '0 : writedata;
  always_ff @(posedge clk)
    if (mem_we)
      for (int i = 0; i < BE_W; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  assign rd_word = in_range ? mem[address] : '0;
  always_comb begin
    v1_d       = stall ? v1_q : rd_acc;
    d1_d       = (~stall & rd_acc) ? rd_word : d1_q;
    src_v      = (READ_LATENCY == 2) ? v1_q : rd_acc;
    src_d      = (READ_LATENCY == 2) ? d1_q : rd_word;
    rdv_d      = stall ? rdv_q : src_v;
    readdata_d = (~stall & src_v) ? src_d : readdata_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v1_q       <= 1'b0;
      d1_q       <= '0;
      rdv_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      v1_q       <= v1_d;
      d1_q       <= d1_d;
      rdv_q      <= rdv_d;
      readdata_q <= readdata_d;
    end
  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q & ~stall;
endmodule

// File: tb/tb_avalon_onchip_ram_pipe.sv
// tb_avalon_onchip_ram_pipe: three RAM instances (lat1, lat2, lat1 with DEPTH=1500) against a queue-based model.
module tb_avalon_onchip_ram_pipe;
`ifdef ONCHIP_RAM_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, clken = 1'b1, reset_req = 1'b0;
  logic cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [10:0] addr = '0;
  logic [3:0] be = '0;
  logic [31:0] wdata = '0;
  logic [2:0] rdv_o, wreq_o, idn_o;
  logic [31:0] rdata_o [3];
  int n_vec = 0, n_bad = 0, beats1 = 0;
  always #5 clk = ~clk;

  avalon_onchip_ram_pipe #(.READ_LATENCY(1), .DEPTH(2048)) u0 (.clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .chipselect(cs), .read(rd), .write(wr), .address(addr), .byteenable(be),
    .writedata(wdata), .readdata(rdata_o[0]), .readdatavalid(rdv_o[0]), .waitrequest(wreq_o[0]), .init_done(idn_o[0]));
  avalon_onchip_ram_pipe #(.READ_LATENCY(2), .DEPTH(2048)) u1 (.clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .chipselect(cs), .read(rd), .write(wr), .address(addr), .byteenable(be),
    .writedata(wdata), .readdata(rdata_o[1]), .readdatavalid(rdv_o[1]), .waitrequest(wreq_o[1]), .init_done(idn_o[1]));
  avalon_onchip_ram_pipe #(.READ_LATENCY(1), .DEPTH(1500)) u2 (.clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .chipselect(cs), .read(rd), .write(wr), .address(addr), .byteenable(be),
    .writedata(wdata), .readdata(rdata_o[2]), .readdatavalid(rdv_o[2]), .waitrequest(wreq_o[2]), .init_done(idn_o[2]));

  bit [31:0] mem_m [3][2048];
  bit [31:0] fd [3][4];
  int fc [3][4];
  int fh [3], fn [3], clr [3];
  bit [31:0] last [3];

  function automatic int lat_of(int k); return (k == 1) ? 2 : 1; endfunction
  function automatic int dep_of(int k); return (k == 2) ? 1500 : 2048; endfunction
  function automatic bit idone(int k); return !SCRUB || clr[k] >= dep_of(k); endfunction
  function automatic bit stall_m(int k); return !clken || reset_req || !idone(k); endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      fh[k] = 0; fn[k] = 0; clr[k] = 0; last[k] = '0;
    end
  endtask

  // one beat per accepted read; it is shown once its remaining unstalled-edge count hits 0
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit st;
      int idx;
      st = stall_m(k);
      if (SCRUB && !idone(k) && clken && !reset_req) begin
        mem_m[k][clr[k]] = '0;
        clr[k]++;
      end
      if (!st) begin
        if (fn[k] > 0 && fc[k][fh[k]] == 0) begin
          last[k] = fd[k][fh[k]];
          fh[k] = (fh[k] + 1) % 4;
          fn[k]--;
        end
        for (int j = 0; j < fn[k]; j++)
          if (fc[k][(fh[k] + j) % 4] > 0) fc[k][(fh[k] + j) % 4]--;
        if (cs && wr) begin
          if (int'(addr) < dep_of(k))
            for (int b = 0; b < 4; b++) if (be[b]) mem_m[k][addr][8*b +: 8] = wdata[8*b +: 8];
        end else if (cs && rd) begin
          idx = (fh[k] + fn[k]) % 4;
          fd[k][idx] = (int'(addr) < dep_of(k)) ? mem_m[k][addr] : '0;
          fc[k][idx] = lat_of(k) - 1;
          fn[k]++;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      bit e;
      e = !stall_m(k) && fn[k] > 0 && fc[k][fh[k]] == 0;
      chk($sformatf("rdv%0d", k), 32'(rdv_o[k]), 32'(e));
      if (e) chk($sformatf("rdata%0d", k), rdata_o[k], fd[k][fh[k]]);
      else if (fn[k] == 0) chk($sformatf("hold%0d", k), rdata_o[k], last[k]);
      chk($sformatf("waitreq%0d", k), 32'(wreq_o[k]), 32'(stall_m(k)));
      chk($sformatf("init_done%0d", k), 32'(idn_o[k]), 32'(idone(k)));
    end
    if (rdv_o[1]) beats1++;
  endtask

  task automatic half(); @(negedge clk); model_check(); endtask
  task automatic fin(); @(posedge clk); model_step(); #1; endtask
  task automatic cyc(); half(); fin(); endtask

  task automatic drive(bit c, bit r, bit w, logic [10:0] a, logic [3:0] b, logic [31:0] d);
    cs = c; rd = r; wr = w; addr = a; be = b; wdata = d;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (n < 3000 && !idn_o[0]) begin
      half();
      if (!idn_o[0]) n++;
      fin();
    end
    chk("init_edges", 32'(n), SCRUB ? 32'd2048 : 32'd0);
  endtask

  typedef struct packed {
    logic cs, rd, wr;
    logic [10:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    logic [2:0] ev;
    logic [31:0] e0, e1, e2;
  } vec_t;
  vec_t tab [8];

  initial begin
    tab[0] = '{1'b1, 1'b0, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF, 3'b000, 32'h0, 32'h0, 32'h0};
    tab[1] = '{1'b1, 1'b0, 1'b1, 11'h010, 4'h1, 32'h000000AA, 3'b000, 32'h0, 32'h0, 32'h0};
    tab[2] = '{1'b1, 1'b0, 1'b1, 11'h600, 4'hF, 32'h12345678, 3'b000, 32'h0, 32'h0, 32'h0};
    tab[3] = '{1'b1, 1'b1, 1'b0, 11'h010, 4'h0, 32'h0, 3'b000, 32'h0, 32'h0, 32'h0};
    tab[4] = '{1'b1, 1'b1, 1'b0, 11'h600, 4'h0, 32'h0, 3'b101, 32'hDEADBEAA, 32'h0, 32'hDEADBEAA};
    tab[5] = '{1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0, 3'b111, 32'h12345678, 32'hDEADBEAA, 32'h0};
    tab[6] = '{1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0, 3'b010, 32'h0, 32'h12345678, 32'h0};
    tab[7] = '{1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0, 3'b000, 32'h0, 32'h0, 32'h0};
    model_reset();
    @(posedge clk); #1;
    half();
    for (int k = 0; k < 3; k++) chk($sformatf("reset_rdata%0d", k), rdata_o[k], 32'h0);
    fin();
    reset_n = 1'b1;
    wait_init();
`ifdef ONCHIP_RAM_SCRUB_EN
    drive(1, 1, 0, 11'h7FF, 4'h0, 32'h0);
    cyc();
    drive(0, 0, 0, 11'h0, 4'h0, 32'h0);
    half();
    chk("scrub_7ff_rdv", 32'(rdv_o[0]), 32'd1);
    chk("scrub_7ff_data", rdata_o[0], 32'h0);
    fin();
    repeat (3) cyc();
`endif
    for (int i = 0; i < 8; i++) begin
      drive(tab[i].cs, tab[i].rd, tab[i].wr, tab[i].a, tab[i].be, tab[i].wd);
      half();
      chk($sformatf("tab%0d_rdv", i), 32'(rdv_o), 32'(tab[i].ev));
      if (tab[i].ev[0]) chk($sformatf("tab%0d_d0", i), rdata_o[0], tab[i].e0);
      if (tab[i].ev[1]) chk($sformatf("tab%0d_d1", i), rdata_o[1], tab[i].e1);
      if (tab[i].ev[2]) chk($sformatf("tab%0d_d2", i), rdata_o[2], tab[i].e2);
      fin();
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 1, 11'(i), 4'hF, 32'hA000_0000 + 32'(i));
      cyc();
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, 11'(i), 4'h0, 32'h0);
      cyc();
    end
    drive(0, 0, 0, 11'h0, 4'h0, 32'h0);
    repeat (4) cyc();
    beats1 = 0;
    drive(1, 1, 0, 11'h001, 4'h0, 32'h0); cyc();
    drive(1, 1, 0, 11'h002, 4'h0, 32'h0); cyc();
    drive(1, 1, 0, 11'h003, 4'h0, 32'h0);
    clken = 1'b0;
    repeat (3) cyc();
    clken = 1'b1;
    cyc();
    drive(0, 0, 0, 11'h0, 4'h0, 32'h0);
    repeat (4) cyc();
    chk("stall_beats", 32'(beats1), 32'd3);
    drive(1, 1, 0, 11'h010, 4'h0, 32'h0);
    cyc();
    drive(0, 0, 0, 11'h0, 4'h0, 32'h0);
    reset_n = 1'b0;
    model_reset();
    half();
    chk("rst_midread_rdv", 32'(rdv_o), 32'd0);
    chk("rst_midread_data", rdata_o[0], 32'h0);
    fin();
    reset_n = 1'b1;
    wait_init();
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 1, 11'h5D0 + 11'(i), 4'hF, $urandom);
      cyc();
    end
    for (int i = 0; i < 1500; i++) begin
      clken = ($urandom % 10) != 0;
      reset_req = ($urandom % 20) == 0;
      drive(($urandom % 4) != 0, $urandom % 2 == 0, $urandom % 3 == 0, 11'h5D0 + 11'($urandom % 64),
            4'($urandom), $urandom);
      cyc();
    end
    clken = 1'b1;
    reset_req = 1'b0;
    drive(0, 0, 0, 11'h0, 4'h0, 32'h0);
    repeat (6) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
